// File: rtl/debug_req_ctrl.sv
// Debug request distributor: per-hart debug IRQ pulses plus an ndmreset stretcher with a done pulse.
// Optional halt-ack timeout is compiled in with `define DEBUG_REQ_TIMEOUT_EN.
module debug_req_ctrl #(
  parameter int NR_CORES        = 1,
  parameter int PULSE_CYCLES    = 4,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NR_CORES-1:0]   dm_debug_req_i,
  input  logic                  dm_ndmreset_i,
  input  logic [NR_CORES-1:0]   hart_halted_i,
  output logic [NR_CORES-1:0]   debug_req_irq,
  output logic                  ndmreset,
  output logic                  ndmreset_done,
  output logic [NR_CORES-1:0]   halt_timeout,
  output logic [2*NR_CORES-1:0] dbg_hart_state,
  output logic [1:0]            dbg_rst_state
);
  // Handshake: none; all inputs are levels sampled every aclk, outputs are registered (event in cycle N shows at N+1).

  localparam int PW = $clog2((PULSE_CYCLES > 2) ? PULSE_CYCLES : 2);
  localparam int RW = $clog2((RST_HOLD_CYCLES > 2) ? RST_HOLD_CYCLES : 2);
`ifdef DEBUG_REQ_TIMEOUT_EN
  localparam int TW = $clog2((TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES : 2);
`endif

  typedef enum logic [1:0] {H_IDLE = 2'd0, H_PULSE = 2'd1, H_WAIT = 2'd2} hart_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_HOLD = 2'd1, R_DONE = 2'd2} rst_state_e;

  generate
    if (NR_CORES < 1 || PULSE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("debug_req_ctrl: count parameters must be >= 1");
    end
  endgenerate

  logic [NR_CORES-1:0] r_req_q;
  logic [NR_CORES-1:0] w_req_rise;
  logic                r_nrst_q;
  logic                w_nrst_rise;

  assign w_req_rise  = dm_debug_req_i & ~r_req_q;
  assign w_nrst_rise = dm_ndmreset_i & ~r_nrst_q;

  rst_state_e      r_rs, w_rs_nxt;
  logic [RW-1:0]   r_rcnt, w_rcnt_nxt;
  logic            w_hold_blk;
  logic            r_ndm, r_done;

  // The hold counter saturates at 0; a still-asserted input keeps us in R_HOLD.
  always_comb begin
    w_rs_nxt   = r_rs;
    w_rcnt_nxt = r_rcnt;
    case (r_rs)
      R_IDLE: begin
        if (w_nrst_rise) begin
          w_rs_nxt   = R_HOLD;
          w_rcnt_nxt = RW'(RST_HOLD_CYCLES - 1);
        end
      end
      R_HOLD: begin
        if (r_rcnt != '0)        w_rcnt_nxt = r_rcnt - RW'(1);
        else if (!dm_ndmreset_i) w_rs_nxt   = R_DONE;
      end
      R_DONE:  w_rs_nxt = R_IDLE;
      default: w_rs_nxt = R_IDLE;
    endcase
  end

  // Blocking covers the rise cycle (reset beats a simultaneous request) and every hold cycle.
  assign w_hold_blk = (r_rs == R_HOLD) || (w_rs_nxt == R_HOLD);

  hart_state_e         r_hs     [NR_CORES];
  hart_state_e         w_hs_nxt [NR_CORES];
  logic [PW-1:0]       r_pcnt     [NR_CORES];
  logic [PW-1:0]       w_pcnt_nxt [NR_CORES];
  logic [NR_CORES-1:0] r_irq, w_irq_nxt;
`ifdef DEBUG_REQ_TIMEOUT_EN
  logic [TW-1:0]       r_tcnt     [NR_CORES];
  logic [TW-1:0]       w_tcnt_nxt [NR_CORES];
  logic [NR_CORES-1:0] r_to, w_to_nxt;
`endif

  always_comb begin
`ifdef DEBUG_REQ_TIMEOUT_EN
    w_to_nxt = r_to;
`endif
    w_irq_nxt = '0;
    for (int i = 0; i < NR_CORES; i++) begin
      w_hs_nxt[i]   = r_hs[i];
      w_pcnt_nxt[i] = r_pcnt[i];
`ifdef DEBUG_REQ_TIMEOUT_EN
      w_tcnt_nxt[i] = r_tcnt[i];
`endif
      case (r_hs[i])
        H_IDLE: begin
          if (w_req_rise[i]) begin
            w_hs_nxt[i]   = H_PULSE;
            w_pcnt_nxt[i] = PW'(PULSE_CYCLES - 1);
`ifdef DEBUG_REQ_TIMEOUT_EN
            w_to_nxt[i]   = 1'b0;
`endif
          end
        end
        H_PULSE: begin
          if (r_pcnt[i] == '0) begin
            w_hs_nxt[i]   = H_WAIT;
`ifdef DEBUG_REQ_TIMEOUT_EN
            w_tcnt_nxt[i] = TW'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            w_pcnt_nxt[i] = r_pcnt[i] - PW'(1);
          end
        end
        H_WAIT: begin
          if (hart_halted_i[i] || !dm_debug_req_i[i]) begin
            w_hs_nxt[i] = H_IDLE;
          end
`ifdef DEBUG_REQ_TIMEOUT_EN
          else if (r_tcnt[i] == '0) begin
            w_hs_nxt[i] = H_IDLE;
            w_to_nxt[i] = 1'b1;
          end else begin
            w_tcnt_nxt[i] = r_tcnt[i] - TW'(1);
          end
`endif
        end
        default: w_hs_nxt[i] = H_IDLE;
      endcase
      if (w_hold_blk) begin
        w_hs_nxt[i] = H_IDLE;
`ifdef DEBUG_REQ_TIMEOUT_EN
        w_to_nxt[i] = r_to[i];
`endif
      end
      w_irq_nxt[i] = (w_hs_nxt[i] == H_PULSE);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_req_q  <= '0;
      r_nrst_q <= 1'b0;
      r_rs     <= R_IDLE;
      r_rcnt   <= '0;
      r_ndm    <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= '0;
      for (int i = 0; i < NR_CORES; i++) begin
        r_hs[i]   <= H_IDLE;
        r_pcnt[i] <= '0;
`ifdef DEBUG_REQ_TIMEOUT_EN
        r_tcnt[i] <= '0;
`endif
      end
`ifdef DEBUG_REQ_TIMEOUT_EN
      r_to <= '0;
`endif
    end else begin
      r_req_q  <= dm_debug_req_i;
      r_nrst_q <= dm_ndmreset_i;
      r_rs     <= w_rs_nxt;
      r_rcnt   <= w_rcnt_nxt;
      r_ndm    <= (w_rs_nxt == R_HOLD);
      r_done   <= (w_rs_nxt == R_DONE);
      r_irq    <= w_irq_nxt;
      for (int i = 0; i < NR_CORES; i++) begin
        r_hs[i]   <= w_hs_nxt[i];
        r_pcnt[i] <= w_pcnt_nxt[i];
`ifdef DEBUG_REQ_TIMEOUT_EN
        r_tcnt[i] <= w_tcnt_nxt[i];
`endif
      end
`ifdef DEBUG_REQ_TIMEOUT_EN
      r_to <= w_to_nxt;
`endif
    end
  end

  assign debug_req_irq = r_irq;
  assign ndmreset      = r_ndm;
  assign ndmreset_done = r_done;
`ifdef DEBUG_REQ_TIMEOUT_EN
  assign halt_timeout  = r_to;
`else
  assign halt_timeout  = '0;
`endif

  always_comb begin
    dbg_hart_state = '0;
    for (int i = 0; i < NR_CORES; i++) begin
      dbg_hart_state[2*i +: 2] = r_hs[i];
    end
  end
  assign dbg_rst_state = r_rs;

endmodule
